// File: rtl/divider_scheduler.sv
// Round-robin front end sharing one pipelined signed divider among NREQ requesters.
// Issues are tagged with the requester ID; returning quotients land in per-requester buffers.
module divider_scheduler #(
    parameter int NREQ     = 4,
    parameter int DIVIDEND = 32,
    parameter int DIVISOR  = 24,
    parameter int QUOTIENT = 32,
    parameter int LATENCY  = 7
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*DIVIDEND-1:0] req_dividend,
    input  logic [NREQ*DIVISOR-1:0]  req_divisor,
    output logic [NREQ-1:0]          rsp_valid,
    input  logic [NREQ-1:0]          rsp_ready,
    output logic [NREQ*QUOTIENT-1:0] rsp_quotient,
    output logic [NREQ-1:0]          rsp_dbz,
    output logic                     div_ivalid,
    output logic [DIVIDEND-1:0]      div_dividend,
    output logic [DIVISOR-1:0]       div_divisor,
    input  logic                     div_ovalid,
    input  logic [QUOTIENT-1:0]      div_quotient,
    output logic                     err_align
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef struct packed {
        logic           valid;
        logic [IDW-1:0] id;
        logic           dbz;
    } tag_t;

    logic [DIVIDEND-1:0] dividend_arr [NREQ];
    logic [DIVISOR-1:0]  divisor_arr  [NREQ];
    logic [QUOTIENT-1:0] rsp_data_reg [NREQ];
    logic [NREQ-1:0]     busy_reg;
    logic [NREQ-1:0]     rsp_valid_reg;
    logic [NREQ-1:0]     rsp_dbz_reg;
    logic [IDW-1:0]      ptr_reg;
    logic [NREQ-1:0]     eligible;
    logic [NREQ-1:0]     grant;
    logic [IDW-1:0]      grant_id;
    logic [IDW-1:0]      cand;
    logic                grant_found;
    logic                issue;
    logic                div_ivalid_reg;
    logic [DIVIDEND-1:0] div_dividend_reg;
    logic [DIVISOR-1:0]  div_divisor_reg;
    logic                err_align_reg;
    tag_t                tag_reg [LATENCY+1];
    tag_t                tag_exit;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_lane
            assign dividend_arr[gi] = req_dividend[gi*DIVIDEND +: DIVIDEND];
            assign divisor_arr[gi]  = req_divisor[gi*DIVISOR +: DIVISOR];
            assign rsp_quotient[gi*QUOTIENT +: QUOTIENT] = rsp_data_reg[gi];
        end
    endgenerate

    assign eligible = req_valid & ~busy_reg;

    // First eligible requester at or after the round-robin pointer, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        grant       = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDW'((int'(ptr_reg) + k) % NREQ);
            if (!grant_found && eligible[cand]) begin
                grant_found = 1'b1;
                grant_id    = cand;
            end
        end
        if (grant_found) begin
            grant[grant_id] = 1'b1;
        end
    end

    assign issue     = grant_found & reset_n;
    assign req_ready = reset_n ? grant : '0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr_reg          <= '0;
            div_ivalid_reg   <= 1'b0;
            div_dividend_reg <= '0;
            div_divisor_reg  <= '0;
        end else begin
            div_ivalid_reg <= issue;
            if (issue) begin
                div_dividend_reg <= dividend_arr[grant_id];
                div_divisor_reg  <= divisor_arr[grant_id];
                ptr_reg          <= (int'(grant_id) == NREQ - 1) ? '0 : grant_id + 1'b1;
            end
        end
    end

    // LATENCY+1 stages: the divider sees the op one cycle after the handshake.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k <= LATENCY; k++) begin
                tag_reg[k] <= '0;
            end
        end else begin
            tag_reg[0].valid <= issue;
            tag_reg[0].id    <= grant_id;
            tag_reg[0].dbz   <= issue && (divisor_arr[grant_id] == '0);
            for (int k = 1; k <= LATENCY; k++) begin
                tag_reg[k] <= tag_reg[k-1];
            end
        end
    end

    assign tag_exit = tag_reg[LATENCY];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_align_reg <= 1'b0;
        end else if (tag_exit.valid != div_ovalid) begin
            err_align_reg <= 1'b1;
        end
    end

    // A valid exiting tag always writes, even without div_ovalid, so no requester deadlocks.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy_reg      <= '0;
            rsp_valid_reg <= '0;
            rsp_dbz_reg   <= '0;
            for (int i = 0; i < NREQ; i++) begin
                rsp_data_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (issue && grant_id == IDW'(i)) begin
                    busy_reg[i] <= 1'b1;
                end else if (rsp_valid_reg[i] && rsp_ready[i]) begin
                    busy_reg[i] <= 1'b0;
                end
                if (tag_exit.valid && tag_exit.id == IDW'(i)) begin
                    rsp_valid_reg[i] <= 1'b1;
                    rsp_dbz_reg[i]   <= tag_exit.dbz;
                    rsp_data_reg[i]  <= tag_exit.dbz ? '1 : div_quotient;
                end else if (rsp_valid_reg[i] && rsp_ready[i]) begin
                    rsp_valid_reg[i] <= 1'b0;
                end
            end
        end
    end

    assign rsp_valid    = rsp_valid_reg;
    assign rsp_dbz      = rsp_dbz_reg;
    assign div_ivalid   = div_ivalid_reg;
    assign div_dividend = div_dividend_reg;
    assign div_divisor  = div_divisor_reg;
    assign err_align    = err_align_reg;

endmodule

// File: tb/tb_divider_scheduler.sv
// Directed bench for divider_scheduler with a behavioural divider and a response scoreboard.
module tb_divider_scheduler;
    localparam int NREQ     = 4;
    localparam int DIVIDEND = 32;
    localparam int DIVISOR  = 24;
    localparam int QUOTIENT = 32;
    localparam int LATENCY  = 7;

    logic                     clock = 1'b0;
    logic                     reset_n;
    logic [NREQ-1:0]          req_valid;
    logic [NREQ-1:0]          req_ready;
    logic [NREQ*DIVIDEND-1:0] req_dividend;
    logic [NREQ*DIVISOR-1:0]  req_divisor;
    logic [NREQ-1:0]          rsp_valid;
    logic [NREQ-1:0]          rsp_ready;
    logic [NREQ*QUOTIENT-1:0] rsp_quotient;
    logic [NREQ-1:0]          rsp_dbz;
    logic                     div_ivalid;
    logic [DIVIDEND-1:0]      div_dividend;
    logic [DIVISOR-1:0]       div_divisor;
    logic                     div_ovalid;
    logic [QUOTIENT-1:0]      div_quotient;
    logic                     err_align;

    int total = 0;
    int bad   = 0;
    logic late  = 1'b0;
    logic sb_on = 1'b0;

    typedef struct {
        int          id;
        logic [31:0] q;
        logic        dbz;
    } exp_t;

    exp_t sb[$];
    int   grant_log[$];
    int   grant_cnt [NREQ];

    always #5 clock = ~clock;

    divider_scheduler #(
        .NREQ(NREQ), .DIVIDEND(DIVIDEND), .DIVISOR(DIVISOR),
        .QUOTIENT(QUOTIENT), .LATENCY(LATENCY)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dividend(req_dividend), .req_divisor(req_divisor),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_quotient(rsp_quotient), .rsp_dbz(rsp_dbz),
        .div_ivalid(div_ivalid), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_ovalid(div_ovalid), .div_quotient(div_quotient),
        .err_align(err_align)
    );

    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [23:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sd;
        sa = a;
        sd = {{8{b[23]}}, b};
        if (b == '0) return '0;
        return sa / sd;
    endfunction

    // Behavioural divider; 'late' delays its result strobe by one extra cycle.
    logic [LATENCY:0] pv;
    logic [31:0]      pq [LATENCY+1];
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pv <= '0;
            for (int k = 0; k <= LATENCY; k++) pq[k] <= '0;
        end else begin
            pv    <= {pv[LATENCY-1:0], div_ivalid};
            pq[0] <= ref_div(div_dividend, div_divisor);
            for (int k = 1; k <= LATENCY; k++) pq[k] <= pq[k-1];
        end
    end
    assign div_ovalid   = late ? pv[LATENCY] : pv[LATENCY-1];
    assign div_quotient = late ? pq[LATENCY] : pq[LATENCY-1];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Scoreboard: push on request handshake, pop and compare on response handshake.
    always @(negedge clock) begin
        exp_t        e;
        logic [23:0] dvs;
        int          hit;
        if (reset_n) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    grant_log.push_back(i);
                    grant_cnt[i]++;
                    if (sb_on) begin
                        dvs   = req_divisor[i*DIVISOR +: DIVISOR];
                        e.id  = i;
                        e.dbz = (dvs == '0);
                        e.q   = e.dbz ? 32'hFFFF_FFFF : ref_div(req_dividend[i*DIVIDEND +: DIVIDEND], dvs);
                        sb.push_back(e);
                    end
                end
                if (sb_on && rsp_valid[i] && rsp_ready[i]) begin
                    hit = -1;
                    for (int j = 0; j < sb.size(); j++) begin
                        if (hit < 0 && sb[j].id == i) hit = j;
                    end
                    chk("sb_expected_entry", 64'(hit >= 0), 64'(1'b1));
                    if (hit >= 0) begin
                        chk("sb_quotient", 64'(rsp_quotient[i*QUOTIENT +: QUOTIENT]), 64'(sb[hit].q));
                        chk("sb_dbz", 64'(rsp_dbz[i]), 64'(sb[hit].dbz));
                        sb.delete(hit);
                    end
                end
            end
        end
    end

    task automatic issue(input int i, input logic [31:0] a, input logic [23:0] b);
        int   n;
        logic ok;
        req_dividend[i*DIVIDEND +: DIVIDEND] = a;
        req_divisor[i*DIVISOR +: DIVISOR]    = b;
        req_valid[i] = 1'b1;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 50) begin
            @(negedge clock);
            if (req_ready[i]) ok = 1'b1;
            else begin
                @(posedge clock); #1;
            end
            n++;
        end
        @(posedge clock); #1;
        req_valid[i] = 1'b0;
        chk("issue_granted", 64'(ok), 64'(1'b1));
    endtask

    task automatic wait_rsp(input int i);
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!rsp_valid[i] && n < 60);
        chk("rsp_arrives", 64'(rsp_valid[i]), 64'(1'b1));
    endtask

    task automatic drain(input int i);
        @(posedge clock); #1;
        rsp_ready[i] = 1'b1;
        @(posedge clock); #1;
        rsp_ready[i] = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'(0));
        chk({tag, "_div_ivalid"}, 64'(div_ivalid), 64'(0));
        chk({tag, "_div_dividend"}, 64'(div_dividend), 64'(0));
        chk({tag, "_div_divisor"}, 64'(div_divisor), 64'(0));
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
        chk({tag, "_rsp_quotient_or"}, 64'(|rsp_quotient), 64'(0));
        chk({tag, "_rsp_dbz"}, 64'(rsp_dbz), 64'(0));
        chk({tag, "_err_align"}, 64'(err_align), 64'(0));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        logic [3:0]  ev;
        logic [31:0] a;
        int          c0;

        for (int i = 0; i < NREQ; i++) grant_cnt[i] = 0;
        reset_n      = 1'b0;
        req_valid    = '1;
        req_dividend = '0;
        req_divisor  = '0;
        rsp_ready    = '0;

        // Reset state, with requests pending that must not be granted.
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk_all_zero("reset");
        @(posedge clock); #1;
        req_valid = '0;
        reset_n   = 1'b1;
        sb_on     = 1'b1;

        // Single op 100/7 from requester 0.
        @(posedge clock); #1;
        req_dividend[0 +: 32] = 32'd100;
        req_divisor[0 +: 24]  = 24'd7;
        req_valid[0] = 1'b1;
        @(negedge clock);
        chk("single_grant", 64'(req_ready), 64'(4'b0001));
        @(posedge clock); #1;
        req_valid[0] = 1'b0;
        @(negedge clock);
        chk("single_div_ivalid", 64'(div_ivalid), 64'(1'b1));
        chk("single_div_dividend", 64'(div_dividend), 64'(32'd100));
        chk("single_div_divisor", 64'(div_divisor), 64'(24'd7));
        n = 1;
        while (!rsp_valid[0] && n < 30) begin
            @(negedge clock);
            n++;
        end
        chk("single_rsp_latency", 64'(n), 64'(9));
        chk("single_quotient", 64'(rsp_quotient[0 +: 32]), 64'(32'd14));

        // Busy until drained; re-issue only the cycle after the response handshake.
        @(posedge clock); #1;
        req_dividend[0 +: 32] = 32'd200;
        req_divisor[0 +: 24]  = 24'd10;
        req_valid[0] = 1'b1;
        repeat (3) begin
            @(negedge clock);
            chk("busy_no_grant", 64'(req_ready[0]), 64'(1'b0));
            chk("busy_rsp_hold", 64'(rsp_valid[0]), 64'(1'b1));
            @(posedge clock); #1;
        end
        rsp_ready[0] = 1'b1;
        @(negedge clock);
        chk("reissue_cycle_d", 64'(req_ready[0]), 64'(1'b0));
        @(posedge clock); #1;
        rsp_ready[0] = 1'b0;
        @(negedge clock);
        chk("reissue_cycle_d1", 64'(req_ready[0]), 64'(1'b1));
        @(posedge clock); #1;
        req_valid[0] = 1'b0;
        wait_rsp(0);
        chk("reissue_quotient", 64'(rsp_quotient[0 +: 32]), 64'(32'd20));
        drain(0);
        chk("sb_empty_1", 64'(sb.size()), 64'(0));

        // Fresh reset so ptr=0, then all four request at once.
        @(posedge clock); #1;
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        req_dividend[0*32 +: 32] = 32'hFFFF_FF9C;  // -100
        req_divisor[0*24 +: 24]  = 24'd7;
        req_dividend[1*32 +: 32] = 32'd1000;
        req_divisor[1*24 +: 24]  = 24'hFF_FFFD;     // -3
        req_dividend[2*32 +: 32] = 32'd7;
        req_divisor[2*24 +: 24]  = 24'd9;
        req_dividend[3*32 +: 32] = 32'h7FFF_FFFF;
        req_divisor[3*24 +: 24]  = 24'd2;
        req_valid = '1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            ev = 4'(1 << k);
            chk("all4_grant", 64'(req_ready), 64'(ev));
            @(posedge clock); #1;
        end
        req_valid = '0;
        rsp_ready = '1;
        for (int c = 4; c <= 12; c++) begin
            @(negedge clock);
            ev = (c >= 9) ? 4'(1 << (c - 9)) : 4'b0000;
            chk("all4_rsp_order", 64'(rsp_valid), 64'(ev));
        end

        // Fairness between requesters 1 and 3 with immediate draining.
        @(posedge clock); #1;
        grant_log.delete();
        req_dividend[1*32 +: 32] = 32'd77;
        req_divisor[1*24 +: 24]  = 24'hFF_FFF9;     // -7
        req_dividend[3*32 +: 32] = 32'hFFFF_FFF7;  // -9
        req_divisor[3*24 +: 24]  = 24'd4;
        req_valid = 4'b1010;
        repeat (60) @(posedge clock);
        #1;
        req_valid = '0;
        repeat (15) @(posedge clock);
        #1;
        rsp_ready = '0;
        chk("fair_enough_grants", 64'(grant_log.size() >= 6), 64'(1'b1));
        for (int j = 0; j < 6; j++) begin
            if (j < grant_log.size()) begin
                chk("fair_alternate", 64'(grant_log[j]), 64'((j % 2 == 0) ? 1 : 3));
            end
        end
        chk("sb_empty_2", 64'(sb.size()), 64'(0));

        // Divide-by-zero, then a normal divide from the same requester.
        issue(2, 32'd55, 24'd0);
        wait_rsp(2);
        chk("dbz_flag", 64'(rsp_dbz[2]), 64'(1'b1));
        chk("dbz_quotient", 64'(rsp_quotient[2*32 +: 32]), 64'(32'hFFFF_FFFF));
        drain(2);
        issue(2, 32'd55, 24'd5);
        wait_rsp(2);
        chk("after_dbz_flag", 64'(rsp_dbz[2]), 64'(1'b0));
        chk("after_dbz_quotient", 64'(rsp_quotient[2*32 +: 32]), 64'(32'd11));
        drain(2);

        // Backpressure on requester 1 while requester 0 keeps being served.
        issue(1, 32'd90, 24'hFF_FFF7);              // 90 / -9
        wait_rsp(1);
        @(posedge clock); #1;
        req_dividend[1*32 +: 32] = 32'd5;
        req_divisor[1*24 +: 24]  = 24'd5;
        req_valid[1] = 1'b1;
        req_dividend[0*32 +: 32] = 32'd30;
        req_divisor[0*24 +: 24]  = 24'd3;
        req_valid[0] = 1'b1;
        rsp_ready[0] = 1'b1;
        c0 = grant_cnt[0];
        repeat (20) begin
            @(negedge clock);
            chk("bp_rsp_valid", 64'(rsp_valid[1]), 64'(1'b1));
            chk("bp_rsp_data", 64'(rsp_quotient[1*32 +: 32]), 64'(32'hFFFF_FFF6));
            chk("bp_no_grant", 64'(req_ready[1]), 64'(1'b0));
            @(posedge clock); #1;
        end
        req_valid = '0;
        chk("bp_others_served", 64'(grant_cnt[0] - c0 > 0), 64'(1'b1));
        drain(1);
        repeat (15) @(posedge clock);
        #1;
        rsp_ready = '0;
        chk("sb_empty_3", 64'(sb.size()), 64'(0));

        // Late divider strobe raises a sticky err_align.
        sb_on = 1'b0;
        late  = 1'b1;
        chk("err_before_fault", 64'(err_align), 64'(1'b0));
        issue(0, 32'd40, 24'd4);
        repeat (12) @(posedge clock);
        @(negedge clock);
        chk("err_align_set", 64'(err_align), 64'(1'b1));
        repeat (6) @(posedge clock);
        @(negedge clock);
        chk("err_align_sticky", 64'(err_align), 64'(1'b1));

        // Asynchronous reset mid-stream clears everything at once.
        @(posedge clock); #1;
        issue(3, 32'd8, 24'd2);
        req_valid = '1;
        reset_n   = 1'b0;
        #1;
        chk_all_zero("midreset");
        req_valid = '0;
        sb.delete();
        late = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        sb_on   = 1'b1;
        issue(3, 32'd100, 24'd7);
        wait_rsp(3);
        a = rsp_quotient[3*32 +: 32];
        chk("post_reset_quotient", 64'(a), 64'(32'd14));
        chk("post_reset_err", 64'(err_align), 64'(1'b0));
        drain(3);
        @(negedge clock);
        chk("sb_empty_final", 64'(sb.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
